// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int WORD_SIZE = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one memory bus with a fixed
// MEM_LAT-cycle strobe and alternating priority on conflicts.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 if_req,
  input  logic [WORD_SIZE-1:0] if_addr,
  output logic                 if_done,
  output logic [WORD_SIZE-1:0] if_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_done,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic [WORD_SIZE-1:0] fetch_count,
  output logic [1:0]           fsm_state
);

  localparam logic [3:0] LAST = 4'(MEM_LAT - 1);

  state_t               state, state_nxt;
  gnt_t                 gnt, win;
  logic                 we_l;
  logic                 prio_d;
  logic [3:0]           cnt;
  logic [WORD_SIZE-1:0] addr_l, wdata_l;

  // Requests are levels held until the matching done pulse; a request is
  // accepted only at an edge that ends an IDLE cycle.
  always_comb begin
    win = GNT_IF;
    if (d_req && (!if_req || prio_d)) win = GNT_D;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (if_req || d_req) state_nxt = ACCESS;
      ACCESS:  if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      gnt         <= GNT_D;
      we_l        <= 1'b0;
      prio_d      <= 1'b1;
      cnt         <= 4'd0;
      addr_l      <= '0;
      wdata_l     <= '0;
      if_rdata    <= '0;
      d_rdata     <= '0;
      fetch_count <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (if_req || d_req) begin
          gnt     <= win;
          addr_l  <= (win == GNT_D) ? d_addr : if_addr;
          wdata_l <= d_wdata;
          we_l    <= (win == GNT_D) && d_we;
          // Whoever wins now loses the next tie.
          prio_d  <= (win == GNT_IF);
          cnt     <= 4'd0;
        end
        ACCESS: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAST) begin
            cnt <= 4'd0;
            if (!we_l) begin
              if (gnt == GNT_IF) if_rdata <= data;
              else               d_rdata  <= data;
            end
          end
        end
        DONE: if (gnt == GNT_IF) fetch_count <= fetch_count + 16'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    readM   = (state == ACCESS) && !we_l;
    writeM  = (state == ACCESS) && we_l;
    address = (state == ACCESS) ? addr_l : '0;
    if_done = (state == DONE) && (gnt == GNT_IF);
    d_done  = (state == DONE) && (gnt == GNT_D);
  end

  assign data      = writeM ? wdata_l : 'z;
  assign fsm_state = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed and random transactions against a
// transaction-level model of arbitration, latency, memory and counters.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        if_req, d_req, d_we;
  logic [15:0] if_addr, d_addr, d_wdata;
  logic        if_done, d_done, readM, writeM;
  logic [15:0] if_rdata, d_rdata, address, fetch_count;
  logic [1:0]  fsm_state;
  wire  [15:0] data;

  logic        if_req1, d_req1, d_we1;
  logic [15:0] if_addr1, d_addr1, d_wdata1;
  logic        if_done1, d_done1, readM1, writeM1;
  logic [15:0] if_rdata1, d_rdata1, address1, fetch_count1;
  logic [1:0]  fsm_state1;
  wire  [15:0] data1;

  logic [15:0] mem [0:65535];

  int          errors = 0;
  int          checks = 0;
  logic        prio_d_m;
  logic [15:0] fc_m, if_rd_m, d_rd_m;
  logic [16:0] exp_q[$];

  mem_port_arbiter #(.MEM_LAT(LAT)) dut (
    .Clk(Clk), .Reset(Reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .readM(readM), .writeM(writeM), .address(address), .data(data),
    .fetch_count(fetch_count), .fsm_state(fsm_state)
  );

  mem_port_arbiter #(.MEM_LAT(1)) dut1 (
    .Clk(Clk), .Reset(Reset),
    .if_req(if_req1), .if_addr(if_addr1), .if_done(if_done1), .if_rdata(if_rdata1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_done(d_done1), .d_rdata(d_rdata1),
    .readM(readM1), .writeM(writeM1), .address(address1), .data(data1),
    .fetch_count(fetch_count1), .fsm_state(fsm_state1)
  );

  // Memory responder: returns mem[address] on reads, parks a known
  // pattern on the bus when idle so a stray DUT driver shows up.
  assign data  = writeM  ? 16'hzzzz : (readM  ? mem[address]  : 16'hC33C);
  assign data1 = writeM1 ? 16'hzzzz : (readM1 ? mem[address1] : 16'hC33C);

  // clock / reset
  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  // Runs one or two requests to completion, starting in an IDLE cycle and
  // returning in the IDLE cycle after the last done.
  task automatic serve(input logic want_if, input logic want_d, input logic [15:0] ia,
                       input logic [15:0] da, input logic [15:0] dw, input logic dwe);
    logic        pend_if, pend_d, win_d, exp_we;
    logic [15:0] exp_addr, exp_rd;
    logic [16:0] e;
    pend_if = want_if;
    pend_d  = want_d;
    if_req  = want_if;
    d_req   = want_d;
    while (pend_if || pend_d) begin
      if_addr = ia; d_addr = da; d_wdata = dw; d_we = dwe;
      @(negedge Clk);
      chk("idle_state", 32'(fsm_state), 32'd0);
      chk("idle_strobes", 32'({readM, writeM, if_done, d_done}), 32'd0);
      chk("idle_addr", 32'(address), 32'd0);
      chk("idle_bus", 32'(data), 32'hC33C);
      chk("fetch_count", 32'(fetch_count), 32'(fc_m));
      win_d    = pend_d && (!pend_if || prio_d_m);
      prio_d_m = !win_d;
      exp_addr = win_d ? da : ia;
      exp_we   = win_d && dwe;
      exp_rd   = mem[exp_addr];
      exp_q.push_back({win_d, exp_rd});
      for (int c = 1; c <= LAT; c++) begin
        next_cycle();
        if_addr = 16'($urandom); d_addr = 16'($urandom);
        d_wdata = 16'($urandom); d_we = 1'($urandom_range(0, 1));
        @(negedge Clk);
        chk("acc_readM", 32'(readM), 32'(!exp_we));
        chk("acc_writeM", 32'(writeM), 32'(exp_we));
        chk("acc_addr", 32'(address), 32'(exp_addr));
        chk("acc_bus", 32'(data), 32'(exp_we ? dw : exp_rd));
        chk("acc_done", 32'({if_done, d_done}), 32'd0);
      end
      next_cycle();
      @(negedge Clk);
      e = exp_q.pop_front();
      if (e[16]) begin
        if (!exp_we) d_rd_m = e[15:0];
        else         mem[exp_addr] = dw;
      end else begin
        if_rd_m = e[15:0];
        fc_m    = fc_m + 16'd1;
      end
      chk("done_if", 32'(if_done), 32'(!e[16]));
      chk("done_d", 32'(d_done), 32'(e[16]));
      chk("done_strobes", 32'({readM, writeM}), 32'd0);
      chk("done_addr", 32'(address), 32'd0);
      chk("done_bus", 32'(data), 32'hC33C);
      chk("if_rdata", 32'(if_rdata), 32'(if_rd_m));
      chk("d_rdata", 32'(d_rdata), 32'(d_rd_m));
      if (e[16]) begin d_req = 1'b0; pend_d = 1'b0; end
      else       begin if_req = 1'b0; pend_if = 1'b0; end
      next_cycle();
    end
  endtask

  initial begin
    logic [1:0] w;
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h6B1D;
    Reset = 1'b1;
    if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
    if_req1 = 0; d_req1 = 0; d_we1 = 0; if_addr1 = 0; d_addr1 = 0; d_wdata1 = 0;
    prio_d_m = 1'b1; fc_m = 0; if_rd_m = 0; d_rd_m = 0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    chk("rst_state", 32'(fsm_state), 32'd0);
    chk("rst_strobes", 32'({readM, writeM, if_done, d_done}), 32'd0);
    chk("rst_addr", 32'(address), 32'd0);
    chk("rst_bus", 32'(data), 32'hC33C);
    chk("rst_rdata", 32'({if_rdata, d_rdata}), 32'd0);
    chk("rst_fetch_count", 32'(fetch_count), 32'd0);
    next_cycle();

    // single fetch, single write, single read
    mem[16'h0010] = 16'h1234;
    serve(1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0000, 1'b0);
    serve(1'b0, 1'b1, 16'h0000, 16'h0020, 16'hBEEF, 1'b1);
    serve(1'b0, 1'b1, 16'h0000, 16'h0020, 16'h0000, 1'b0);
    chk("fetch_once", 32'(if_rdata), 32'h1234);

    // simultaneous requests alternate, nobody starves
    for (int r = 0; r < 10; r++)
      serve(1'b1, 1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));

    for (int r = 0; r < 16; r++) begin
      w = 2'($urandom_range(1, 3));
      serve(w[0], w[1], 16'($urandom_range(0, 63)), 16'($urandom_range(0, 63)),
            16'($urandom), 1'($urandom_range(0, 1)));
    end

    // reset in the second access cycle of a fetch
    if_req = 1'b1; if_addr = 16'h0010;
    next_cycle();
    next_cycle();
    Reset = 1'b1;
    next_cycle();
    Reset = 1'b0; if_req = 1'b0;
    prio_d_m = 1'b1; fc_m = 0; if_rd_m = 0; d_rd_m = 0;
    @(negedge Clk);
    chk("rstacc_state", 32'(fsm_state), 32'd0);
    chk("rstacc_strobes", 32'({readM, writeM, if_done, d_done}), 32'd0);
    chk("rstacc_rdata", 32'({if_rdata, d_rdata}), 32'd0);
    chk("rstacc_fetch_count", 32'(fetch_count), 32'd0);
    next_cycle();
    @(negedge Clk);
    chk("rstacc_no_done", 32'({if_done, d_done}), 32'd0);
    next_cycle();
    serve(1'b1, 1'b1, 16'h0005, 16'h0006, 16'h0000, 1'b0);

    // fetch counter wrap
    force dut.fetch_count = 16'hFFFF;
    #1 release dut.fetch_count;
    fc_m = 16'hFFFF;
    serve(1'b1, 1'b0, 16'h0030, 16'h0000, 16'h0000, 1'b0);
    @(negedge Clk);
    chk("fetch_wrap", 32'(fetch_count), 32'h0000);
    next_cycle();

    // MEM_LAT=1 instance: address stays latched, done in cycle 2
    d_req1 = 1'b1; d_we1 = 1'b0; d_addr1 = 16'h0042;
    next_cycle();
    d_addr1 = 16'h0099; d_we1 = 1'b1;
    @(negedge Clk);
    chk("lat1_readM", 32'({readM1, writeM1}), 32'b10);
    chk("lat1_addr", 32'(address1), 32'h0042);
    next_cycle();
    @(negedge Clk);
    chk("lat1_done", 32'(d_done1), 32'd1);
    chk("lat1_rdata", 32'(d_rdata1), 32'(mem[16'h0042]));
    chk("lat1_done_addr", 32'(address1), 32'd0);
    d_req1 = 1'b0;
    next_cycle();
    @(negedge Clk);
    chk("lat1_idle", 32'({fsm_state1, d_done1}), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
